// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the PCPU RV32 core.
// Latches the decoded control word, operands and register addresses for EX.
// It detects load-use hazards against the instruction in EX, inserts the
// bubble itself, and counts inserted bubbles with a saturating counter.
module id_ex_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_RegWrite,
  input  logic            id_MemWrite,
  input  logic            id_MemRead,
  input  logic            id_ALUSrc,
  input  logic [4:0]      id_ALUOp,
  input  logic [2:0]      id_NPCOp,
  input  logic [1:0]      id_WDSel,
  input  logic [2:0]      id_DMType,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rd1,
  output logic [XLEN-1:0] ex_rd2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_RegWrite,
  output logic            ex_MemWrite,
  output logic            ex_MemRead,
  output logic            ex_ALUSrc,
  output logic [4:0]      ex_ALUOp,
  output logic [2:0]      ex_NPCOp,
  output logic [1:0]      ex_WDSel,
  output logic [2:0]      ex_DMType,
  output logic            load_use,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic take_bubble;
  logic capture;

  // Conservative load-use detect: a valid decode instruction names the
  // destination of a load currently in EX. Independent of stall/flush.
  always_comb begin
    load_use = id_valid & ex_valid & ex_MemRead & (ex_rd != 5'd0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  end

  // Update priority: flush bubble, then stall hold, then load-use bubble,
  // otherwise capture decode.
  always_comb begin
    take_bubble = flush | (~stall & load_use);
    capture     = ~flush & ~stall & ~load_use;
  end

  // Pipeline register; a bubble clears every field including the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || take_bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_RegWrite <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_ALUOp    <= '0;
      ex_NPCOp    <= '0;
      ex_WDSel    <= '0;
      ex_DMType   <= '0;
    end else if (capture) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rd1      <= id_rd1;
      ex_rd2      <= id_rd2;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_RegWrite <= id_RegWrite;
      ex_MemWrite <= id_MemWrite;
      ex_MemRead  <= id_MemRead;
      ex_ALUSrc   <= id_ALUSrc;
      ex_ALUOp    <= id_ALUOp;
      ex_NPCOp    <= id_NPCOp;
      ex_WDSel    <= id_WDSel;
      ex_DMType   <= id_DMType;
    end
  end

  // Saturating count of inserted bubbles (flush or load-use, never holds).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (take_bubble && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic        mr;
    logic        as;
    logic [4:0]  aluop;
    logic [2:0]  npc;
    logic [1:0]  wd;
    logic [2:0]  dm;
  } ex_t;

  logic clk = 1'b0;
  logic rst, stall, flush;
  logic id_valid;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc;
  logic [4:0] id_ALUOp;
  logic [2:0] id_NPCOp;
  logic [1:0] id_WDSel;
  logic [2:0] id_DMType;

  logic ex_valid;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc;
  logic [4:0] ex_ALUOp;
  logic [2:0] ex_NPCOp;
  logic [1:0] ex_WDSel;
  logic [2:0] ex_DMType;
  logic load_use;
  logic [15:0] bubble_cnt;

  logic s_valid;
  logic [31:0] s_pc, s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic s_RegWrite, s_MemWrite, s_MemRead, s_ALUSrc;
  logic [4:0] s_ALUOp;
  logic [2:0] s_NPCOp;
  logic [1:0] s_WDSel;
  logic [2:0] s_DMType;
  logic s_load_use;
  logic [3:0] s_bubble_cnt;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite),
    .id_MemRead(id_MemRead), .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
    .id_NPCOp(id_NPCOp), .id_WDSel(id_WDSel), .id_DMType(id_DMType),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
    .ex_MemRead(ex_MemRead), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
    .ex_NPCOp(ex_NPCOp), .ex_WDSel(ex_WDSel), .ex_DMType(ex_DMType),
    .load_use(load_use), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance on the same stimulus, for saturation.
  id_ex_reg #(.XLEN(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite),
    .id_MemRead(id_MemRead), .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
    .id_NPCOp(id_NPCOp), .id_WDSel(id_WDSel), .id_DMType(id_DMType),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_rd1(s_rd1), .ex_rd2(s_rd2),
    .ex_imm(s_imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
    .ex_RegWrite(s_RegWrite), .ex_MemWrite(s_MemWrite),
    .ex_MemRead(s_MemRead), .ex_ALUSrc(s_ALUSrc), .ex_ALUOp(s_ALUOp),
    .ex_NPCOp(s_NPCOp), .ex_WDSel(s_WDSel), .ex_DMType(s_DMType),
    .load_use(s_load_use), .bubble_cnt(s_bubble_cnt)
  );

  ex_t id_now, dut_ex, sat_ex;
  assign id_now = {id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
                   id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc,
                   id_ALUOp, id_NPCOp, id_WDSel, id_DMType};
  assign dut_ex = {ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
                   ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc,
                   ex_ALUOp, ex_NPCOp, ex_WDSel, ex_DMType};
  assign sat_ex = {s_valid, s_pc, s_rd1, s_rd2, s_imm, s_rs1, s_rs2, s_rd,
                   s_RegWrite, s_MemWrite, s_MemRead, s_ALUSrc,
                   s_ALUOp, s_NPCOp, s_WDSel, s_DMType};

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: EX contents as a record, bubble count as an integer.
  ex_t m_ex;
  int  m_cnt;

  function automatic bit hazard(input ex_t ex, input ex_t id);
    return id.valid && ex.valid && ex.mr && ex.rd != 0 &&
           (ex.rd == id.rs1 || ex.rd == id.rs2);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ex  = '0;
      m_cnt = 0;
    end else if (flush) begin
      m_ex = '0;
      m_cnt++;
    end else if (stall) begin
      m_ex = m_ex;
    end else if (hazard(m_ex, id_now)) begin
      m_ex = '0;
      m_cnt++;
    end else begin
      m_ex = id_now;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("ex_fields", dut_ex, m_ex);
      chk("load_use", load_use, hazard(m_ex, id_now));
      chk("bubble_cnt", bubble_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
      chk("sat_ex_fields", sat_ex, m_ex);
      chk("sat_load_use", s_load_use, hazard(m_ex, id_now));
      chk("sat_bubble_cnt", s_bubble_cnt, (m_cnt > 15) ? 15 : m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_id();
    id_valid    = ($urandom % 4) != 0;
    id_pc       = $urandom;
    id_rd1      = $urandom;
    id_rd2      = $urandom;
    id_imm      = $urandom;
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    id_rd       = 5'($urandom_range(0, 3));
    id_RegWrite = 1'($urandom);
    id_MemWrite = 1'($urandom);
    id_MemRead  = 1'($urandom);
    id_ALUSrc   = 1'($urandom);
    id_ALUOp    = 5'($urandom);
    id_NPCOp    = 3'($urandom);
    id_WDSel    = 2'($urandom);
    id_DMType   = 3'($urandom);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_id();
    #12 rst = 1'b0;
    started = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_id();
      id_valid = 1'b1;
      tick();
    end

    // Asynchronous reset mid-cycle clears everything immediately.
    #2 rst = 1'b1;
    #1;
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_ex_pc", ex_pc, 32'h0);
    chk("rst_bubble_cnt", bubble_cnt, 16'd0);
    chk("rst_load_use", load_use, 1'b0);
    tick();
    #2 rst = 1'b0;

    // Capture.
    rand_id();
    id_valid = 1'b1; id_pc = 32'h100; id_ALUOp = 5'b00011;
    id_RegWrite = 1'b1; id_MemRead = 1'b0;
    tick();
    chk("cap_ex_pc", ex_pc, 32'h100);
    chk("cap_ex_aluop", ex_ALUOp, 5'b00011);
    chk("cap_ex_valid", ex_valid, 1'b1);

    // Load-use: lw x5 in EX, dependent on rs2.
    rand_id();
    id_valid = 1'b1; id_MemRead = 1'b1; id_rd = 5'd5; id_RegWrite = 1'b1;
    tick();
    rand_id();
    id_valid = 1'b1; id_rs1 = 5'd7; id_rs2 = 5'd5; id_rd = 5'd9;
    id_MemRead = 1'b0; id_RegWrite = 1'b1;
    #1 chk("lu_raised", load_use, 1'b1);
    tick();
    chk("lu_bubble_valid", ex_valid, 1'b0);
    chk("lu_bubble_regwrite", ex_RegWrite, 1'b0);
    chk("lu_bubble_cnt", bubble_cnt, 16'd1);
    chk("lu_dropped", load_use, 1'b0);
    tick();
    chk("lu_dep_valid", ex_valid, 1'b1);
    chk("lu_dep_rs2", ex_rs2, 5'd5);
    chk("lu_dep_rd", ex_rd, 5'd9);

    // Load to x0 never hazards.
    rand_id();
    id_valid = 1'b1; id_MemRead = 1'b1; id_rd = 5'd0;
    tick();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_MemRead = 1'b0;
    #1 chk("lu_x0", load_use, 1'b0);

    // Stall hold.
    rand_id();
    id_valid = 1'b1; id_pc = 32'h200; id_MemRead = 1'b0;
    tick();
    chk("stall_load_pc", ex_pc, 32'h200);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick();
      chk("stall_hold_pc", ex_pc, 32'h200);
      chk("stall_hold_cnt", bubble_cnt, 16'd1);
    end
    stall = 1'b0;
    rand_id();
    id_valid = 1'b1; id_pc = 32'h300; id_MemRead = 1'b0;
    tick();
    chk("stall_release_pc", ex_pc, 32'h300);

    // Flush beats stall and load-use.
    rand_id();
    id_valid = 1'b1; id_MemRead = 1'b1; id_rd = 5'd6;
    tick();
    rand_id();
    id_valid = 1'b1; id_rs1 = 5'd6; id_NPCOp = 3'd5;
    stall = 1'b1; flush = 1'b1;
    #1 chk("flush_lu_seen", load_use, 1'b1);
    tick();
    chk("flush_valid", ex_valid, 1'b0);
    chk("flush_npcop", ex_NPCOp, 3'd0);
    chk("flush_cnt", bubble_cnt, 16'd2);
    stall = 1'b0; flush = 1'b0;

    // Invalid decode never hazards, captures as invalid.
    rand_id();
    id_valid = 1'b1; id_MemRead = 1'b1; id_rd = 5'd8;
    tick();
    rand_id();
    id_valid = 1'b0; id_rs1 = 5'd8;
    #1 chk("inv_lu", load_use, 1'b0);
    tick();
    chk("inv_ex_valid", ex_valid, 1'b0);
    chk("inv_cnt", bubble_cnt, 16'd2);

    // Saturation of the narrow counter.
    flush = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_id();
      tick();
    end
    flush = 1'b0;
    chk("sat_cnt_15", s_bubble_cnt, 4'd15);
    chk("wide_cnt_22", bubble_cnt, 16'd22);

    // Randomized traffic with one mid-run asynchronous reset.
    for (int i = 0; i < 2000; i++) begin
      rand_id();
      stall = ($urandom % 4) == 0;
      flush = ($urandom % 10) == 0;
      tick();
      if (i == 1000) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    stall = 1'b0; flush = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
